// File: rtl/demux_1_2_buffered.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_2_buffered
// Purpose  : Receive side of a 2:1 mux path. One WIDTH-bit input stream with a
//            per-word select is steered into two output channels. Each channel
//            has its own DEPTH-entry FIFO and a valid/ready handshake. With
//            STRICT=1, a sticky error flag reports any break in the 0,1,0,1
//            select alternation.
// Ports    : clk         rising-edge clock
//            rst         asynchronous reset, active high
//            in_data     input word
//            in_sel      target channel (0 -> out0, 1 -> out1)
//            in_valid    input word present
//            in_ready    input accepted when in_valid & in_ready
//            out0_data   channel 0 head-of-FIFO word (holds last word when empty)
//            out0_valid  channel 0 FIFO non-empty
//            out0_ready  channel 0 consumer pops when out0_valid & out0_ready
//            out1_data   channel 1 head-of-FIFO word (holds last word when empty)
//            out1_valid  channel 1 FIFO non-empty
//            out1_ready  channel 1 consumer pops when out1_valid & out1_ready
//            seq_err     sticky select-alternation violation flag
// Revision : 1.0 - initial release
// ============================================================================
module demux_1_2_buffered #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 2,
  parameter bit STRICT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [0:0] {
    EXP0 = 1'b0,
    EXP1 = 1'b1
  } chk_state_t;

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       ready_ch;
  logic [WIDTH-1:0] head [2];
  logic             accept;
  chk_state_t       state;

  assign ready_ch = {out1_ready, out0_ready};
  // Ready depends only on the fullness of the addressed channel; a full
  // channel never blocks words destined for the other one.
  assign in_ready = ~rst & ~full[in_sel];
  assign accept   = in_valid & in_ready;

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr;
      logic [WIDTH-1:0] last;

      // Extra pointer MSB distinguishes full from empty when indices match.
      assign full[ch]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign empty[ch] = (wr_ptr == rd_ptr);
      assign push[ch]  = accept && (in_sel == 1'(ch));
      assign pop[ch]   = ~empty[ch] & ready_ch[ch];
      // When empty, keep presenting the most recently shown word.
      assign head[ch]  = empty[ch] ? last : mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          last   <= '0;
        end else begin
          if (push[ch]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[ch])  rd_ptr <= rd_ptr + 1'b1;
          if (!empty[ch]) last <= mem[rd_ptr[AW-1:0]];
        end
      end

      // Storage needs no reset: it is only observed while the FIFO is non-empty.
      always_ff @(posedge clk) begin
        if (push[ch]) mem[wr_ptr[AW-1:0]] <= in_data;
      end
    end
  endgenerate

  assign out0_data  = head[0];
  assign out0_valid = ~empty[0];
  assign out1_data  = head[1];
  assign out1_valid = ~empty[1];

  // Alternation checker. After any accepted word the next expected select is
  // the inverse of that word's select, which also resyncs after an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EXP0;
      seq_err <= 1'b0;
    end else if (STRICT && accept) begin
      if (in_sel != logic'(state)) seq_err <= 1'b1;
      state <= in_sel ? EXP0 : EXP1;
    end
  end

endmodule
`default_nettype wire
